// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a 32x8 single-port synchronous-read memory.
// Serialises port requests into IDLE -> ISSUE (-> RESP) accesses and returns read data per port.
module mem_arbiter #(
    parameter int AW        = 5,
    parameter int DW        = 8,
    parameter int FIXED_PRI = 0,
    parameter int MAX_WAIT  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data_in,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_data_out,
    output logic          busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [1:0]    r_state;
    logic          r_win;
    logic          r_we;
    logic          r_last;
    logic [3:0]    r_wait_cnt;
    logic          r_busy;
    logic          r_m0_gnt, r_m1_gnt;
    logic          r_m0_rvalid, r_m1_rvalid;
    logic [DW-1:0] r_m0_rdata, r_m1_rdata;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_data_in;
    logic          r_mem_rd, r_mem_wr;

    logic          w_any;
    logic          w_tie;
    logic          w_win;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    // Winner selection: a lone requester always wins; ties go by mode.
    always_comb begin
        w_any = m0_req | m1_req;
        w_tie = m0_req & m1_req;
        w_win = m1_req;
        if (w_tie) begin
            if (FIXED_PRI != 0) w_win = (r_wait_cnt == WAIT_LIM);
            else                w_win = ~r_last;
        end
        w_we    = w_win ? m1_we    : m0_we;
        w_addr  = w_win ? m1_addr  : m0_addr;
        w_wdata = w_win ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_win         <= 1'b0;
            r_we          <= 1'b0;
            r_last        <= 1'b1;
            r_wait_cnt    <= 4'd0;
            r_busy        <= 1'b0;
            r_m0_gnt      <= 1'b0;
            r_m1_gnt      <= 1'b0;
            r_m0_rvalid   <= 1'b0;
            r_m1_rvalid   <= 1'b0;
            r_m0_rdata    <= '0;
            r_m1_rdata    <= '0;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
        end else begin
            r_m0_gnt    <= 1'b0;
            r_m1_gnt    <= 1'b0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state       <= S_ISSUE;
                        r_busy        <= 1'b1;
                        r_win         <= w_win;
                        r_we          <= w_we;
                        r_mem_addr    <= w_addr;
                        r_mem_data_in <= w_wdata;
                        r_mem_rd      <= ~w_we;
                        r_mem_wr      <= w_we;
                        r_m0_gnt      <= ~w_win;
                        r_m1_gnt      <= w_win;
                        r_last        <= w_win;
                        // Port 1 loss count only matters in fixed mode; it never exceeds the limit.
                        if (FIXED_PRI != 0) begin
                            if (w_win)
                                r_wait_cnt <= 4'd0;
                            else if (w_tie && r_wait_cnt < WAIT_LIM)
                                r_wait_cnt <= r_wait_cnt + 4'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_mem_rd <= 1'b0;
                    r_mem_wr <= 1'b0;
                    if (r_we) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (r_win) begin
                        r_m1_rdata  <= mem_data_out;
                        r_m1_rvalid <= 1'b1;
                    end else begin
                        r_m0_rdata  <= mem_data_out;
                        r_m0_rvalid <= 1'b1;
                    end
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_mem_rd <= 1'b0;
                    r_mem_wr <= 1'b0;
                end
            endcase
        end
    end

    assign m0_gnt      = r_m0_gnt;
    assign m1_gnt      = r_m1_gnt;
    assign m0_rvalid   = r_m0_rvalid;
    assign m1_rvalid   = r_m1_rvalid;
    assign m0_rdata    = r_m0_rdata;
    assign m1_rdata    = r_m1_rdata;
    assign mem_addr    = r_mem_addr;
    assign mem_data_in = r_mem_data_in;
    assign mem_rd      = r_mem_rd;
    assign mem_wr      = r_mem_wr;
    assign busy        = r_busy;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the 32x8 single-port synchronous-read memory.
- Port 0 is the CPU data/fetch path; port 1 is the loader/debug path.
- Serialises requests, drives the memory's addr/data_in/rd/wr strobes, and returns read data to the winning port with a per-port valid pulse.
- Supports round-robin arbitration or fixed priority with starvation protection.

Parameters:
- AW, 5, address width; matches the 32-entry memory.
- DW, 8, data width.
- FIXED_PRI, 0, 0 = round-robin; 1 = port 0 has priority, subject to the MAX_WAIT limit.
- MAX_WAIT, 4, fixed mode only: number of consecutive losses by port 1 after which port 1 wins once. Range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  port 0 request; held until m0_gnt is seen high.
- m0_we  in  1  port 0 direction: 1 = write, 0 = read.
- m0_addr  in  AW  port 0 address.
- m0_wdata  in  DW  port 0 write data.
- m0_gnt  out  1  port 0 grant; one-cycle pulse.
- m0_rvalid  out  1  port 0 read data valid; one-cycle pulse.
- m0_rdata  out  DW  port 0 read data; held until the next port 0 read completes.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1.
- mem_addr  out  AW  memory address.
- mem_data_in  out  DW  memory write data.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_data_out  in  DW  memory read data; valid the cycle after mem_rd is sampled.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values (asynchronous): state=IDLE, all gnt/rvalid=0, m0_rdata=m1_rdata=0, mem_addr=0, mem_data_in=0, mem_rd=mem_wr=0, last_winner=1 (so port 0 wins the first tie), wait_cnt=0.
- All outputs are registered.
- State machine (IDLE, ISSUE, RESP):
  - IDLE: if no req, stay. Otherwise pick a winner and, on the edge, latch winner/we/addr/wdata into mem_addr/mem_data_in/mem_rd/mem_wr, set winner's gnt=1, go to ISSUE.
  - ISSUE: exactly one of mem_rd/mem_wr is high and gnt is high (one cycle). The memory performs the access on the closing edge. On that edge: clear strobes and gnt; write -> IDLE, read -> RESP.
  - RESP: mem_data_out is valid. On the edge, copy mem_data_out into the winner's rdata register, pulse the winner's rvalid for the following cycle, go to IDLE.
- Latency from req sampled in IDLE (cycle 0):
  - gnt in cycle 1.
  - Write committed at the end of cycle 1.
  - rvalid and rdata in cycle 3.
- Throughput: one write per 2 cycles, one read per 3 cycles. The rvalid cycle overlaps the next IDLE.
- Round-robin arbitration:
  - Only one port requesting: that port wins.
  - Both requesting: the port that is not last_winner wins.
  - last_winner updates on every grant.
- Fixed-priority arbitration:
  - Port 0 wins ties; wait_cnt increments on each tie that port 1 loses.
  - When wait_cnt==MAX_WAIT, port 1 wins the tie instead.
  - wait_cnt clears whenever port 1 is granted.
  - wait_cnt saturates and never wraps.
- Request rules:
  - A requester may drop req before its grant (withdrawal); no access is issued for it.
  - req/we/addr/wdata are sampled only in IDLE. Changes during ISSUE or RESP are ignored until the next IDLE.
  - A requester still holding req in the cycle after gnt is treated as a new request.
- Ordering: accesses complete strictly in grant order. A read granted after a write to the same address returns the new data.
- Reset mid-operation:
  - rst during ISSUE drops mem_wr immediately, so that write is not guaranteed to complete.
  - rst during RESP discards the read: no rvalid, rdata cleared.
  - Memory contents are not affected by rst.
- Address width is AW bits, so there is no out-of-range access; wrap-around is inherent.

Test Plan:
- Single write then read, port 0: write addr 5 data 0xA7 -> m0_gnt in cycle 1, mem_wr=1 with mem_addr=5. Then read addr 5 -> m0_rvalid 3 cycles after req sampled, m0_rdata=0xA7, mem_rd high for exactly 1 cycle.
- Round-robin contention (FIXED_PRI=0): both ports hold read req continuously -> grants alternate 0,1,0,1. Each port's rvalid carries its own address's data; no cycle has both gnt high.
- Fixed priority with starvation (FIXED_PRI=1, MAX_WAIT=4): both ports request continuously -> port 0 granted 4 times, then port 1 once, then the pattern repeats.
- Write/read hazard: port 0 writes addr 31 = 0x3C while port 1 simultaneously requests a read of addr 31, port 0 winning -> m1_rdata=0x3C. Also check that a withdrawn request (m1_req dropped before grant) produces no mem strobe.
- Reset mid-read: assert rst during RESP -> all outputs return to reset values immediately, no rvalid pulse. After release, the next request is served normally with port 0 winning the first tie.
